// File: rtl/eth_tx_arbiter.sv
// Frame-atomic TX scheduler: arbitrates ARP, CMD and DATA frame sources onto the single MAC
// AXIS stream, with inter-frame gap, start timeout and maximum-length enforcement.
module eth_tx_arbiter #(
   parameter int unsigned IFG_CYCLES        = 12,
   parameter int unsigned MAX_FRAME_LEN     = 1518,
   parameter int unsigned START_TIMEOUT     = 64,
   parameter int unsigned DATA_STARVE_LIMIT = 4
) (
   input  logic       CLK_125M,
   input  logic       SYS_RST,
   input  logic       TRIG_TX_ARP,
   input  logic       TRIG_TX_CMD,
   input  logic       DATA_REQ,
   output logic       ARP_START,
   output logic       CMD_START,
   output logic       DATA_START,
   input  logic [7:0] ARP_TDATA,
   input  logic       ARP_TVALID,
   input  logic       ARP_TLAST,
   output logic       ARP_TREADY,
   input  logic [7:0] CMD_TDATA,
   input  logic       CMD_TVALID,
   input  logic       CMD_TLAST,
   output logic       CMD_TREADY,
   input  logic [7:0] DATA_TDATA,
   input  logic       DATA_TVALID,
   input  logic       DATA_TLAST,
   output logic       DATA_TREADY,
   output logic [7:0] RGMII_TX_DATA,
   output logic       RGMII_TX_VALID,
   output logic       RGMII_TX_LAST,
   input  logic       RGMII_TX_READY,
   output logic [1:0] TX_GRANT,
   output logic       TX_BUSY,
   output logic       ERR_TIMEOUT,
   output logic       ERR_OVERLEN
);

   localparam int unsigned LenW    = $clog2(MAX_FRAME_LEN + 1);
   localparam int unsigned TmoW    = (START_TIMEOUT > 1) ? $clog2(START_TIMEOUT) : 1;
   localparam int unsigned IfgW    = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;
   localparam int unsigned StarveW = $clog2(DATA_STARVE_LIMIT + 1);

   localparam logic [LenW-1:0]    LenLast   = LenW'(MAX_FRAME_LEN - 1);
   localparam logic [TmoW-1:0]    TmoLast   = TmoW'(START_TIMEOUT - 1);
   localparam logic [IfgW-1:0]    IfgLast   = IfgW'(IFG_CYCLES - 1);
   localparam logic [StarveW-1:0] StarveMax = StarveW'(DATA_STARVE_LIMIT);

   localparam logic [1:0] GntNone = 2'd0;
   localparam logic [1:0] GntArp  = 2'd1;
   localparam logic [1:0] GntCmd  = 2'd2;
   localparam logic [1:0] GntData = 2'd3;

   typedef enum logic [2:0] {StIdle, StStart, StXfer, StDrain, StIfg} state_e;

   state_e             state_q, state_d;
   logic [1:0]         grant_q, grant_d;
   logic               arp_pend_q, arp_pend_d;
   logic               cmd_pend_q, cmd_pend_d;
   logic [StarveW-1:0] starve_q, starve_d;
   logic [TmoW-1:0]    tmo_q, tmo_d;
   logic [LenW-1:0]    len_q, len_d;
   logic [IfgW-1:0]    ifg_q, ifg_d;
   logic               arp_start_q, arp_start_d;
   logic               cmd_start_q, cmd_start_d;
   logic               data_start_q, data_start_d;
   logic               err_tmo_q, err_tmo_d;
   logic               err_ovl_q, err_ovl_d;

   logic       src_valid, src_last, src_ready;
   logic [7:0] src_data;
   logic       pass, hs, len_at_max;
   logic [1:0] pick;

   // Stream mux; the first beat may already pass while still in START.
   always_comb begin
      src_valid = 1'b0;
      src_last  = 1'b0;
      src_data  = '0;
      case (grant_q)
         GntArp: begin
            src_valid = ARP_TVALID;
            src_last  = ARP_TLAST;
            src_data  = ARP_TDATA;
         end
         GntCmd: begin
            src_valid = CMD_TVALID;
            src_last  = CMD_TLAST;
            src_data  = CMD_TDATA;
         end
         GntData: begin
            src_valid = DATA_TVALID;
            src_last  = DATA_TLAST;
            src_data  = DATA_TDATA;
         end
         default: ;
      endcase

      pass       = (state_q == StXfer) || ((state_q == StStart) && src_valid);
      len_at_max = (len_q == LenLast);

      RGMII_TX_VALID = pass && src_valid;
      RGMII_TX_DATA  = pass ? src_data : 8'h00;
      RGMII_TX_LAST  = pass && src_valid && (src_last || len_at_max);
      hs             = RGMII_TX_VALID && RGMII_TX_READY;

      src_ready   = pass ? RGMII_TX_READY : (state_q == StDrain);
      ARP_TREADY  = src_ready && (grant_q == GntArp);
      CMD_TREADY  = src_ready && (grant_q == GntCmd);
      DATA_TREADY = src_ready && (grant_q == GntData);
   end

   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      tmo_d        = tmo_q;
      len_d        = len_q;
      ifg_d        = ifg_q;
      starve_d     = starve_q;
      arp_start_d  = 1'b0;
      cmd_start_d  = 1'b0;
      data_start_d = 1'b0;
      err_tmo_d    = 1'b0;
      err_ovl_d    = 1'b0;

      pick = GntNone;
      if (state_q == StIdle) begin
         if (DATA_REQ && (starve_q == StarveMax)) begin
            pick = GntData;
         end else if (arp_pend_q) begin
            pick = GntArp;
         end else if (cmd_pend_q) begin
            pick = GntCmd;
         end else if (DATA_REQ) begin
            pick = GntData;
         end
      end

      // A new trigger on the granting cycle stays pending for a later frame.
      arp_pend_d = TRIG_TX_ARP || (arp_pend_q && (pick != GntArp));
      cmd_pend_d = TRIG_TX_CMD || (cmd_pend_q && (pick != GntCmd));

      if (!DATA_REQ || (pick == GntData)) begin
         starve_d = '0;
      end else if (((pick == GntArp) || (pick == GntCmd)) && (starve_q != StarveMax)) begin
         starve_d = starve_q + 1'b1;
      end

      case (state_q)
         StIdle: begin
            if (pick != GntNone) begin
               grant_d      = pick;
               arp_start_d  = (pick == GntArp);
               cmd_start_d  = (pick == GntCmd);
               data_start_d = (pick == GntData);
               tmo_d        = '0;
               len_d        = '0;
               state_d      = StStart;
            end
         end
         StStart, StXfer: begin
            if (pass) begin
               state_d = StXfer;
               if (hs) begin
                  len_d = len_q + 1'b1;
                  if (src_last) begin
                     grant_d = GntNone;
                     ifg_d   = '0;
                     state_d = StIfg;
                  end else if (len_at_max) begin
                     err_ovl_d = 1'b1;
                     state_d   = StDrain;
                  end
               end
            end else if (tmo_q == TmoLast) begin
               err_tmo_d = 1'b1;
               grant_d   = GntNone;
               ifg_d     = '0;
               state_d   = StIfg;
            end else begin
               tmo_d = tmo_q + 1'b1;
            end
         end
         StDrain: begin
            if (src_valid && src_last) begin
               grant_d = GntNone;
               ifg_d   = '0;
               state_d = StIfg;
            end
         end
         StIfg: begin
            if (ifg_q == IfgLast) begin
               state_d = StIdle;
            end else begin
               ifg_d = ifg_q + 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge CLK_125M or posedge SYS_RST) begin
      if (SYS_RST) begin
         state_q      <= StIdle;
         grant_q      <= GntNone;
         arp_pend_q   <= 1'b0;
         cmd_pend_q   <= 1'b0;
         starve_q     <= '0;
         tmo_q        <= '0;
         len_q        <= '0;
         ifg_q        <= '0;
         arp_start_q  <= 1'b0;
         cmd_start_q  <= 1'b0;
         data_start_q <= 1'b0;
         err_tmo_q    <= 1'b0;
         err_ovl_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         arp_pend_q   <= arp_pend_d;
         cmd_pend_q   <= cmd_pend_d;
         starve_q     <= starve_d;
         tmo_q        <= tmo_d;
         len_q        <= len_d;
         ifg_q        <= ifg_d;
         arp_start_q  <= arp_start_d;
         cmd_start_q  <= cmd_start_d;
         data_start_q <= data_start_d;
         err_tmo_q    <= err_tmo_d;
         err_ovl_q    <= err_ovl_d;
      end
   end

   assign ARP_START   = arp_start_q;
   assign CMD_START   = cmd_start_q;
   assign DATA_START  = data_start_q;
   assign TX_GRANT    = grant_q;
   assign TX_BUSY     = (state_q != StIdle);
   assign ERR_TIMEOUT = err_tmo_q;
   assign ERR_OVERLEN = err_ovl_q;

endmodule

// File: tb/tb_eth_tx_arbiter.sv
// Directed bench for eth_tx_arbiter: priority, starvation, timeout, overlength and reset.
module tb_eth_tx_arbiter;

   logic       clk = 1'b0;
   logic       rst;
   logic       trig_arp, trig_cmd, data_req, rdy;
   logic [2:0] sv, sl;
   logic [7:0] sd [3];
   logic       arp_start, cmd_start, data_start;
   logic       arp_tready, cmd_tready, data_tready;
   logic [7:0] tx_data;
   logic       tx_valid, tx_last, tx_busy, err_tmo, err_ovl;
   logic [1:0] tx_grant;

   int n_run = 0;
   int n_fail = 0;

   // Monitor bookkeeping, sampled mid-cycle
   int cyc = 0, fbeat = 0, flast = 0, rg_beats = 0, data_bad = 0;
   int last_cyc = 0, gap = 0, tmo_n = 0, ovl_n = 0, ovl_cyc = 0, starts = 0;

   always #4 clk = ~clk;

   eth_tx_arbiter dut (
      .CLK_125M      (clk),
      .SYS_RST       (rst),
      .TRIG_TX_ARP   (trig_arp),
      .TRIG_TX_CMD   (trig_cmd),
      .DATA_REQ      (data_req),
      .ARP_START     (arp_start),
      .CMD_START     (cmd_start),
      .DATA_START    (data_start),
      .ARP_TDATA     (sd[0]),
      .ARP_TVALID    (sv[0]),
      .ARP_TLAST     (sl[0]),
      .ARP_TREADY    (arp_tready),
      .CMD_TDATA     (sd[1]),
      .CMD_TVALID    (sv[1]),
      .CMD_TLAST     (sl[1]),
      .CMD_TREADY    (cmd_tready),
      .DATA_TDATA    (sd[2]),
      .DATA_TVALID   (sv[2]),
      .DATA_TLAST    (sl[2]),
      .DATA_TREADY   (data_tready),
      .RGMII_TX_DATA (tx_data),
      .RGMII_TX_VALID(tx_valid),
      .RGMII_TX_LAST (tx_last),
      .RGMII_TX_READY(rdy),
      .TX_GRANT      (tx_grant),
      .TX_BUSY       (tx_busy),
      .ERR_TIMEOUT   (err_tmo),
      .ERR_OVERLEN   (err_ovl)
   );

   always @(negedge clk) begin
      cyc = cyc + 1;
      if (arp_start || cmd_start || data_start) begin
         fbeat = 0;
         flast = 0;
         starts = starts + 1;
      end
      if (tx_valid && rdy) begin
         fbeat = fbeat + 1;
         rg_beats = rg_beats + 1;
         if (tx_data != 8'(fbeat)) data_bad = data_bad + 1;
         if (fbeat == 1) gap = cyc - last_cyc - 1;
         if (tx_last) begin
            flast = fbeat;
            last_cyc = cyc;
         end
      end
      if (err_tmo) tmo_n = tmo_n + 1;
      if (err_ovl) begin
         ovl_n = ovl_n + 1;
         ovl_cyc = cyc;
      end
   end

   function automatic logic src_rdy(input int s);
      case (s)
         0: return arp_tready;
         1: return cmd_tready;
         default: return data_tready;
      endcase
   endfunction

   task automatic pulse(input logic a, input logic c);
      @(posedge clk); #2;
      trig_arp = a;
      trig_cmd = c;
      @(posedge clk); #2;
      trig_arp = 1'b0;
      trig_cmd = 1'b0;
   endtask

   task automatic wait_start(input int budget, output int src, output int waited);
      src = -1;
      waited = budget;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (arp_start) src = 0;
         else if (cmd_start) src = 1;
         else if (data_start) src = 2;
         if (src >= 0) begin
            waited = i + 1;
            break;
         end
      end
   endtask

   // Source model: beat b carries data b, TLAST on beat last_at (0 = never).
   task automatic send(input int s, input int n, input int last_at, input logic tog,
                       input int budget, output logic done);
      int b = 1;
      done = 1'b0;
      for (int c = 0; c < budget && !done; c++) begin
         @(posedge clk); #2;
         sv[s] = 1'b1;
         sd[s] = 8'(b);
         sl[s] = (b == last_at);
         rdy = tog ? (c % 2 == 1) : 1'b1;
         @(negedge clk);
         if (src_rdy(s)) begin
            if (b == n) done = 1'b1;
            b++;
         end
      end
      @(posedge clk); #2;
      sv[s] = 1'b0;
      sl[s] = 1'b0;
      rdy = 1'b1;
   endtask

   task automatic wait_idle(input int budget);
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (!tx_busy) break;
      end
   endtask

   task automatic test_reset;
      logic [10:0] outs;
      repeat (3) @(negedge clk);
      outs = {tx_busy, tx_valid, tx_last, err_tmo, err_ovl, arp_start, cmd_start, data_start,
              arp_tready, cmd_tready, data_tready};
      n_run++;
      if (outs !== 11'd0) begin
         n_fail++;
         $display("FAIL reset_outs: got %b want 0", outs);
      end
      n_run++;
      if (tx_grant !== 2'd0 || tx_data !== 8'd0) begin
         n_fail++;
         $display("FAIL reset_grant_data: got grant %0d data %0d want 0 0", tx_grant, tx_data);
      end
      @(posedge clk); #2;
      rst = 1'b0;
      repeat (2) @(negedge clk);
      n_run++;
      if (tx_busy !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_idle: busy got %b want 0", tx_busy);
      end
   endtask

   task automatic test_single_arp;
      int s, w, b0, bad;
      logic done;
      b0 = rg_beats;
      pulse(1'b1, 1'b0);
      @(negedge clk);
      n_run++;
      if (arp_start !== 1'b0) begin
         n_fail++;
         $display("FAIL arp_start_early: got %b want 0", arp_start);
      end
      wait_start(4, s, w);
      n_run++;
      if (s !== 0 || w !== 1) begin
         n_fail++;
         $display("FAIL arp_start: got src %0d after %0d want src 0 after 1", s, w);
      end
      n_run++;
      if (tx_grant !== 2'd1 || tx_busy !== 1'b1) begin
         n_fail++;
         $display("FAIL arp_grant: got grant %0d busy %b want 1 1", tx_grant, tx_busy);
      end
      send(0, 42, 42, 1'b0, 200, done);
      n_run++;
      if (done !== 1'b1 || rg_beats - b0 !== 42 || flast !== 42 || data_bad !== 0) begin
         n_fail++;
         $display("FAIL arp_frame: got done %b beats %0d last %0d bad %0d want 1 42 42 0",
                  done, rg_beats - b0, flast, data_bad);
      end
      bad = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (!tx_busy || tx_grant != 2'd0 || tx_valid) bad++;
      end
      @(negedge clk);
      n_run++;
      if (bad !== 0 || tx_busy !== 1'b0) begin
         n_fail++;
         $display("FAIL arp_ifg: got bad %0d busy %b want 0 0", bad, tx_busy);
      end
   endtask

   task automatic test_priority;
      int s, w, b0;
      logic done;
      b0 = rg_beats;
      pulse(1'b1, 1'b1);
      data_req = 1'b1;
      wait_start(5, s, w);
      n_run++;
      if (s !== 0) begin
         n_fail++;
         $display("FAIL prio_first: got src %0d want 0", s);
      end
      send(0, 10, 10, 1'b0, 100, done);
      wait_start(100, s, w);
      n_run++;
      if (s !== 1) begin
         n_fail++;
         $display("FAIL prio_second: got src %0d want 1", s);
      end
      send(1, 10, 10, 1'b0, 100, done);
      n_run++;
      if (gap < 12) begin
         n_fail++;
         $display("FAIL prio_gap1: got %0d want >=12", gap);
      end
      wait_start(100, s, w);
      data_req = 1'b0;
      n_run++;
      if (s !== 2) begin
         n_fail++;
         $display("FAIL prio_third: got src %0d want 2", s);
      end
      send(2, 10, 10, 1'b0, 100, done);
      n_run++;
      if (gap < 12 || rg_beats - b0 !== 30) begin
         n_fail++;
         $display("FAIL prio_gap2: got gap %0d beats %0d want >=12 30", gap, rg_beats - b0);
      end
      wait_idle(50);
   endtask

   task automatic test_starve;
      int s, w;
      logic done;
      int exp_seq [10] = '{0, 0, 0, 0, 2, 0, 0, 0, 0, 2};
      pulse(1'b1, 1'b0);
      data_req = 1'b1;
      for (int k = 0; k < 10; k++) begin
         wait_start(100, s, w);
         n_run++;
         if (s !== exp_seq[k]) begin
            n_fail++;
            $display("FAIL starve_grant%0d: got src %0d want %0d", k, s, exp_seq[k]);
         end
         if (k < 9) pulse(1'b1, 1'b0);
         if (s >= 0) send(s, 4, 4, 1'b0, 100, done);
      end
      data_req = 1'b0;
      wait_start(100, s, w);
      n_run++;
      if (s !== 0) begin
         n_fail++;
         $display("FAIL starve_arp_kept: got src %0d want 0", s);
      end
      if (s >= 0) send(s, 4, 4, 1'b0, 100, done);
      wait_idle(50);
   endtask

   task automatic test_timeout;
      int s, w, b0, t0, n, b1;
      logic done;
      pulse(1'b0, 1'b1);
      wait_start(5, s, w);
      data_req = 1'b1;
      b0 = rg_beats;
      t0 = tmo_n;
      n = 0;
      for (int i = 1; i <= 200; i++) begin
         @(negedge clk);
         if (err_tmo) begin
            n = i;
            break;
         end
      end
      n_run++;
      if (s !== 1 || n !== 64) begin
         n_fail++;
         $display("FAIL tmo_delay: got src %0d delay %0d want 1 64", s, n);
      end
      n_run++;
      if (tx_grant !== 2'd0 || rg_beats !== b0) begin
         n_fail++;
         $display("FAIL tmo_state: got grant %0d beats %0d want 0 0", tx_grant, rg_beats - b0);
      end
      wait_start(40, s, w);
      data_req = 1'b0;
      n_run++;
      if (s !== 2 || tmo_n - t0 !== 1) begin
         n_fail++;
         $display("FAIL tmo_next: got src %0d pulses %0d want 2 1", s, tmo_n - t0);
      end
      b1 = rg_beats;
      send(2, 5, 5, 1'b0, 100, done);
      n_run++;
      if (rg_beats - b1 !== 5 || flast !== 5) begin
         n_fail++;
         $display("FAIL tmo_after: got beats %0d last %0d want 5 5", rg_beats - b1, flast);
      end
      wait_idle(50);
   endtask

   task automatic test_overlen;
      int s, w, b0, o0, d0;
      logic done;
      data_req = 1'b1;
      wait_start(5, s, w);
      data_req = 1'b0;
      b0 = rg_beats;
      o0 = ovl_n;
      d0 = data_bad;
      send(2, 1600, 1600, 1'b0, 2000, done);
      n_run++;
      if (s !== 2 || done !== 1'b1 || rg_beats - b0 !== 1518 || flast !== 1518) begin
         n_fail++;
         $display("FAIL ovl_frame: got src %0d done %b beats %0d last %0d want 2 1 1518 1518",
                  s, done, rg_beats - b0, flast);
      end
      n_run++;
      if (ovl_n - o0 !== 1 || ovl_cyc - last_cyc !== 1 || data_bad !== d0) begin
         n_fail++;
         $display("FAIL ovl_err: got pulses %0d offset %0d bad %0d want 1 1 0",
                  ovl_n - o0, ovl_cyc - last_cyc, data_bad - d0);
      end
      wait_idle(50);
      n_run++;
      if (tx_busy !== 1'b0) begin
         n_fail++;
         $display("FAIL ovl_idle: busy got %b want 0", tx_busy);
      end
   endtask

   task automatic test_reset_mid;
      int s, w, s0, b0, d0;
      logic done;
      logic [11:0] outs;
      pulse(1'b1, 1'b0);
      wait_start(5, s, w);
      send(0, 100, 0, 1'b1, 20, done);
      pulse(1'b0, 1'b1);
      @(posedge clk); #2;
      sv[0] = 1'b1;
      #1;
      n_run++;
      if (tx_valid !== 1'b1 || tx_grant !== 2'd1) begin
         n_fail++;
         $display("FAIL mid_pre: got valid %b grant %0d want 1 1", tx_valid, tx_grant);
      end
      @(negedge clk); #1;
      rst = 1'b1;
      #1;
      outs = {tx_busy, tx_valid, tx_last, err_tmo, err_ovl, arp_start, cmd_start, data_start,
              arp_tready, cmd_tready, data_tready, |tx_grant};
      n_run++;
      if (outs !== 12'd0 || tx_data !== 8'd0) begin
         n_fail++;
         $display("FAIL mid_reset: got %b data %0d want 0 0", outs, tx_data);
      end
      sv[0] = 1'b0;
      @(posedge clk); #2;
      rst = 1'b0;
      s0 = starts;
      repeat (30) @(negedge clk);
      n_run++;
      if (starts !== s0 || tx_busy !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_pend: got starts %0d busy %b want 0 0", starts - s0, tx_busy);
      end
      b0 = rg_beats;
      d0 = data_bad;
      pulse(1'b1, 1'b0);
      wait_start(5, s, w);
      send(0, 8, 8, 1'b0, 100, done);
      n_run++;
      if (s !== 0 || rg_beats - b0 !== 8 || flast !== 8 || data_bad !== d0) begin
         n_fail++;
         $display("FAIL mid_restart: got src %0d beats %0d last %0d bad %0d want 0 8 8 0",
                  s, rg_beats - b0, flast, data_bad - d0);
      end
   endtask

   initial begin
      rst = 1'b1;
      trig_arp = 1'b0;
      trig_cmd = 1'b0;
      data_req = 1'b0;
      rdy = 1'b1;
      sv = '0;
      sl = '0;
      for (int i = 0; i < 3; i++) sd[i] = 8'h00;
      test_reset;
      test_single_arp;
      test_priority;
      test_starve;
      test_timeout;
      test_overlen;
      test_reset_mid;
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
